bit_run_length_encoder: RTL
===========================

// Module: bit_run_length_encoder
// PURPOSE
//  Downstream stage of the registered AND datapath. Consumes its 1-bit result stream
//  (valid/ready) and emits run-length records {bit, length} into a small output FIFO.
//  Compresses long constant stretches before the trace/capture logic.
//  Fully synchronous to CLK. Asynchronous active-low reset.
// PARAMETERS
//  LEN_W  8  width of run-length field; max run per record = 2**LEN_W-1
//  DEPTH  2  output record FIFO entries; power of 2, >=2
// PORTS
//  CLK          in   1      clock, rising edge
//  ASYNCRESETN  in   1      asynchronous reset, active low; deassert sync to CLK externally
//  I            in   1      input bit (AND-stage result)
//  I_valid      in   1      I is valid this cycle
//  flush        in   1      close current run; qualified by I_ready like I_valid
//  I_ready      out  1      stage accepts I/flush this cycle
//  O_bit        out  1      bit value of head record
//  O_len        out  LEN_W  run length of head record (1..2**LEN_W-1)
//  O_valid      out  1      head record valid
//  O_ready      in   1      consumer takes head record
// BEHAVIOUR
//  - Reset (ASYNCRESETN=0, immediate): state=IDLE, cur_bit=0, len=0, FIFO empty;
//    O_valid=0, O_bit=0, O_len=0, I_ready=1.
//  - accept = I_valid & I_ready; fl = flush & I_ready; I_ready = !fifo_full (comb).
//  - FSM IDLE: accept -> cur_bit<=I, len<=1, go RUN. fl alone -> no-op, stay IDLE.
//  - FSM RUN, accept with I==cur_bit:
//      len<2**LEN_W-1 -> len<=len+1;
//      len==2**LEN_W-1 -> push {cur_bit,len}, len<=1 (saturation split, stay RUN).
//  - FSM RUN, accept with I!=cur_bit: push {cur_bit,len}; cur_bit<=I, len<=1.
//  - FSM RUN, fl: push the current run with the accepted bit (if any) applied first, then go IDLE.
//    If the accepted bit differs from cur_bit, or saturates the run, two records would be needed.
//    Required: push the old run; the new bit starts a run of 1 and stays in RUN.
//    flush is held by the caller until a cycle where only one push is needed.
//    At most one push per cycle, always.
//  - Length arithmetic is unsigned LEN_W; never wraps; len is never 0 in RUN.
//  - FIFO: push and pop in the same cycle are legal when non-empty; occupancy is unchanged.
//    No push when full (guaranteed by I_ready).
//    O_* = head entry, registered; a record is visible the cycle after its closing accept.
//  - O_valid=1 & O_ready=0: O_bit/O_len held stable until taken.
//  - Mid-operation reset: in-flight run and all FIFO records are discarded; no partial record emitted.
// STRUCTURE
//  - Package bit_rle_pkg: typedef enum {IDLE, RUN} rle_state_t;
//    typedef struct packed {logic bit; logic [LEN_W-1:0] len;} rle_rec_t; localparam LEN_MAX.
//  - Sub-module rle_record_fifo (DEPTH x rle_rec_t; CLK, ASYNCRESETN, push, pop, full, empty, head).
//  - Top holds the FSM, cur_bit and len registers, and push/record muxing.
// TESTING
//  1 Reset: hold ASYNCRESETN=0 mid-run with 2 records queued -> O_valid=0, I_ready=1;
//    after release, the first bit starts a fresh run.
//  2 Bits 1,1,1,0,0 then flush, O_ready=1 -> records {1,3}, {0,2}, then IDLE.
//  3 LEN_W=3: 9 consecutive 1s, then 0, then flush -> {1,7}, {1,2}, {0,1}.
//  4 Backpressure: O_ready=0, DEPTH=2; alternate 1,0,1,0 -> two records fill the FIFO;
//    I_ready=0 and the held input is not consumed.
//    Raise O_ready -> {1,1}, {0,1}, {1,1} in order, no loss.
//  5 Simultaneous push+pop with FIFO at 1 entry -> occupancy stays 1, order preserved.
//  6 flush in IDLE and flush while I_ready=0 -> no record; when flush is repeated with
//    I_ready=1, exactly one record is emitted.

Source files
------------

// File: rtl/bit_rle_pkg.sv
// Shared types and default sizing for the bit run-length encoder slice.
package bit_rle_pkg;

  // Encoder FSM: IDLE means no run is open; RUN means cur_bit/len describe an open run.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rle_state_t;

  // Default record geometry; the modules take these as parameter defaults.
  localparam int LEN_W_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 2;

  // Largest run length one record can carry for a given length-field width.
  function automatic int rle_len_max(input int len_w);
    return (1 << len_w) - 1;
  endfunction

endpackage

// File: rtl/rle_record_fifo.sv
// Small record FIFO holding {bit, len} run records; head is taken straight from storage.
module rle_record_fifo
  import bit_rle_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             push,
  input  logic [LEN_W:0]   push_rec,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LEN_W:0]   head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [LEN_W:0] mem_q [DEPTH];
  logic [LEN_W:0] mem_d [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; push and pop may coincide.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset discards every queued record.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bit_run_length_encoder.sv
// Run-length encoder for a 1-bit valid/ready stream; emits {bit, len} records via a FIFO.
module bit_run_length_encoder
  import bit_rle_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I,
  input  logic             I_valid,
  input  logic             flush,
  output logic             I_ready,
  output logic             O_bit,
  output logic [LEN_W-1:0] O_len,
  output logic             O_valid,
  input  logic             O_ready
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(rle_len_max(LEN_W));
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  rle_state_t       state_q, state_d;
  logic             cur_bit_q, cur_bit_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic             accept, fl;
  logic             push;
  logic             push_bit;
  logic [LEN_W-1:0] push_len;
  logic             fifo_full, fifo_empty;
  logic [LEN_W:0]   fifo_head;

  assign I_ready = !fifo_full;
  assign accept  = I_valid & I_ready;
  assign fl      = flush & I_ready;

  // Run tracking: extend, split on change or saturation, close on flush (one push max).
  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    len_d     = len_q;
    push      = 1'b0;
    push_bit  = cur_bit_q;
    push_len  = len_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_bit_d = I;
          if (fl) begin
            push     = 1'b1;
            push_bit = I;
            push_len = LEN_ONE;
            len_d    = '0;
          end else begin
            len_d   = LEN_ONE;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if ((I != cur_bit_q) || (len_q == LEN_MAX)) begin
            // Old run closes here; a concurrent flush stays pending for a later cycle.
            push      = 1'b1;
            cur_bit_d = I;
            len_d     = LEN_ONE;
          end else if (fl) begin
            push     = 1'b1;
            push_len = len_q + LEN_ONE;
            len_d    = '0;
            state_d  = IDLE;
          end else begin
            len_d = len_q + LEN_ONE;
          end
        end else if (fl) begin
          push    = 1'b1;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, current bit and length registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= IDLE;
      cur_bit_q <= 1'b0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_bit_q <= cur_bit_d;
      len_q     <= len_d;
    end
  end

  rle_record_fifo #(
    .LEN_W (LEN_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (push),
    .push_rec    ({push_bit, push_len}),
    .pop         (O_ready),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head)
  );

  assign O_valid = !fifo_empty;
  assign O_bit   = fifo_head[LEN_W];
  assign O_len   = fifo_head[LEN_W-1:0];

endmodule
